// File: rtl/ff_jk_pkg.sv
// Shared definitions for the JK flip-flop checker: FSM state encoding and
// the single-bit JK next-state function used by the reference model.
package ff_jk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2
  } state_e;

  // 00 hold, 10 set, 01 reset, 11 toggle
  function automatic logic jk_next(input logic i_j, input logic i_k, input logic i_q);
    return (i_j & ~i_q) | (~i_k & i_q);
  endfunction

endpackage

// File: rtl/ff_jk_err_cnt.sv
// Saturating error-cycle counter with sticky flag; a clear in the same cycle
// as an increment wins, so that error is dropped.
module ff_jk_err_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iClr,
  input  logic             iInc,
  output logic [CNT_W-1:0] oCnt,
  output logic             oSticky
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sticky;

  // Count error cycles up to saturation; clear has priority over increment
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_cnt    <= CNT_ZERO;
      r_sticky <= 1'b0;
    end else if (iClr) begin
      r_cnt    <= CNT_ZERO;
      r_sticky <= 1'b0;
    end else if (iInc) begin
      r_sticky <= 1'b1;
      if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else begin
        r_cnt <= r_cnt;
      end
    end else begin
      r_cnt    <= r_cnt;
      r_sticky <= r_sticky;
    end
  end

  assign oCnt    = r_cnt;
  assign oSticky = r_sticky;

endmodule

// File: rtl/ff_jk_checker.sv
// Observes J/K stimulus and Q/Qn results of a JK flip-flop bank, runs its own
// model of the bank and reports deviations as pulse, sticky flag and count.
module ff_jk_checker
  import ff_jk_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iEn,
  input  logic             iClr,
  input  logic [WIDTH-1:0] iJ,
  input  logic [WIDTH-1:0] iK,
  input  logic [WIDTH-1:0] iQ,
  input  logic [WIDTH-1:0] iQn,
  output logic             oSync,
  output logic [WIDTH-1:0] oExpQ,
  output logic             oErr,
  output logic [WIDTH-1:0] oErrMask,
  output logic             oErrSticky,
  output logic [CNT_W-1:0] oErrCnt
);

  localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};

  state_e           r_state;
  logic             r_sync;
  logic [WIDTH-1:0] r_expq;
  logic             r_err;
  logic [WIDTH-1:0] r_mask;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_expq_nxt;
  logic [WIDTH-1:0] w_jk_obs;
  logic [WIDTH-1:0] w_jk_mdl;
  logic [WIDTH-1:0] w_qerr;
  logic [WIDTH-1:0] w_cerr;
  logic [WIDTH-1:0] w_mask;
  logic             w_err;

  // Next Q predicted from the observed Q and from the model's own Q
  always_comb begin
    w_jk_obs = W_ZERO;
    w_jk_mdl = W_ZERO;
    for (int i = 0; i < WIDTH; i++) begin
      w_jk_obs[i] = jk_next(iJ[i], iK[i], iQ[i]);
      w_jk_mdl[i] = jk_next(iJ[i], iK[i], r_expq[i]);
    end
  end

  // FSM, error detection and model update; a disabled monitor checks nothing
  always_comb begin
    w_state_nxt = r_state;
    w_expq_nxt  = r_expq;
    w_qerr      = W_ZERO;
    w_cerr      = W_ZERO;
    if (!iEn) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          w_cerr      = ~(iQn ^ iQ);
          w_expq_nxt  = w_jk_obs;
          w_state_nxt = ST_TRACK;
        end
        ST_TRACK: begin
          w_cerr = ~(iQn ^ iQ);
          w_qerr = iQ ^ r_expq;
          // Resync on a Q mismatch so one fault yields one error cycle
          if (|w_qerr) begin
            w_expq_nxt = w_jk_obs;
          end else begin
            w_expq_nxt = w_jk_mdl;
          end
          w_state_nxt = ST_TRACK;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign w_mask = w_qerr | w_cerr;
  assign w_err  = |w_mask;

  // State, model and error-pulse registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= ST_IDLE;
      r_sync  <= 1'b0;
      r_expq  <= W_ZERO;
      r_err   <= 1'b0;
      r_mask  <= W_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_sync  <= (w_state_nxt == ST_TRACK);
      r_expq  <= w_expq_nxt;
      r_err   <= w_err;
      r_mask  <= w_mask;
    end
  end

  ff_jk_err_cnt #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iClr    (iClr),
    .iInc    (w_err),
    .oCnt    (oErrCnt),
    .oSticky (oErrSticky)
  );

  assign oSync    = r_sync;
  assign oExpQ    = r_expq;
  assign oErr     = r_err;
  assign oErrMask = r_mask;

endmodule

// File: tb/tb_ff_jk_checker.sv
// Directed table-driven bench for ff_jk_checker (WIDTH=2, CNT_W=2).
module tb_ff_jk_checker;

  localparam int WIDTH = 2;
  localparam int CNT_W = 2;
  localparam int NVEC  = 22;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] j, k, q, qn;
  logic             sync;
  logic [WIDTH-1:0] expq;
  logic             err;
  logic [WIDTH-1:0] mask;
  logic             sticky;
  logic [CNT_W-1:0] cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       en;
    logic       clr;
    logic [1:0] j;
    logic [1:0] k;
    logic [1:0] q;
    logic [1:0] qn;
    logic       sync;
    logic [1:0] expq;
    logic       err;
    logic [1:0] mask;
    logic       sticky;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs [NVEC];

  ff_jk_checker #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .iClk       (clk),
    .iRst_n     (rst_n),
    .iEn        (en),
    .iClr       (clr),
    .iJ         (j),
    .iK         (k),
    .iQ         (q),
    .iQn        (qn),
    .oSync      (sync),
    .oExpQ      (expq),
    .oErr       (err),
    .oErrMask   (mask),
    .oErrSticky (sticky),
    .oErrCnt    (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic e_sync, input logic [1:0] e_expq,
                         input logic e_err, input logic [1:0] e_mask,
                         input logic e_sticky, input logic [1:0] e_cnt);
    chk("oSync", idx, {31'd0, sync}, {31'd0, e_sync});
    chk("oExpQ", idx, {30'd0, expq}, {30'd0, e_expq});
    chk("oErr", idx, {31'd0, err}, {31'd0, e_err});
    chk("oErrMask", idx, {30'd0, mask}, {30'd0, e_mask});
    chk("oErrSticky", idx, {31'd0, sticky}, {31'd0, e_sticky});
    chk("oErrCnt", idx, {30'd0, cnt}, {30'd0, e_cnt});
  endtask

  initial begin
    // en clr   j      k      q      qn   | sync expq  err mask  sticky cnt
    // Correct flip-flop: bit0 runs JK 00,10,01,11,11; bit1 toggles
    vecs[0]  = '{1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 2'b10, 2'b10, 2'b10, 2'b01, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, 1'b0, 2'b11, 2'b10, 2'b00, 2'b11, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'd0};
    vecs[3]  = '{1'b1, 1'b0, 2'b10, 2'b11, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0};
    vecs[4]  = '{1'b1, 1'b0, 2'b11, 2'b11, 2'b00, 2'b11, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'd0};
    vecs[5]  = '{1'b1, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0};
    // Set both, then bit0 stuck at 0 for one cycle, then resynced
    vecs[6]  = '{1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b11, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'd0};
    vecs[7]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01, 1'b1, 2'b10, 1'b1, 2'b01, 1'b1, 2'd1};
    vecs[8]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01, 1'b1, 2'b10, 1'b0, 2'b00, 1'b1, 2'd1};
    // Disable mid-TRACK, re-enable, complement fault in ACQUIRE
    vecs[9]  = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 2'd1};
    vecs[10] = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 2'd1};
    vecs[11] = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b11, 1'b1, 2'b11, 1'b1, 2'b11, 1'b1, 2'd2};
    vecs[12] = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 2'b11, 1'b0, 2'b00, 1'b1, 2'd2};
    // Clear, then persistent bit0 fault saturates at 3, then clear beats a fault
    vecs[13] = '{1'b1, 1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'd0};
    vecs[14] = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b10, 2'b01, 1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 2'd1};
    vecs[15] = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b10, 2'b01, 1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 2'd2};
    vecs[16] = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b10, 2'b01, 1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 2'd3};
    vecs[17] = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b10, 2'b01, 1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 2'd3};
    vecs[18] = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b10, 2'b01, 1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 2'd3};
    vecs[19] = '{1'b1, 1'b1, 2'b01, 2'b01, 2'b10, 2'b01, 1'b1, 2'b11, 1'b1, 2'b01, 1'b0, 2'd0};
    vecs[20] = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'd0};
    // Bit1 Q fault, leaves the checker busy before the async reset
    vecs[21] = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 2'b10, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1, 2'd1};

    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    j     = 2'b00;
    k     = 2'b00;
    q     = 2'b00;
    qn    = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all(-1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      en  = vecs[i].en;
      clr = vecs[i].clr;
      j   = vecs[i].j;
      k   = vecs[i].k;
      q   = vecs[i].q;
      qn  = vecs[i].qn;
      @(posedge clk);
      #1;
      chk_all(i, vecs[i].sync, vecs[i].expq, vecs[i].err, vecs[i].mask,
              vecs[i].sticky, vecs[i].cnt);
    end

    // Asynchronous reset between edges must clear everything at once
    #2;
    rst_n = 1'b0;
    #1;
    chk_all(100, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0);

    // After release the FSM restarts from IDLE: two edges before oSync
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    clr   = 1'b0;
    j     = 2'b00;
    k     = 2'b00;
    q     = 2'b00;
    qn    = 2'b11;
    @(posedge clk);
    #1;
    chk_all(101, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    chk_all(102, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ff_jk_checker.md
# ff_jk_checker

Synthesizable protocol checker for the JK flip-flop interface: the observing end that watches the J/K stimulus driven into a JK flip-flop bank and the Q/Qn outputs it returns. It keeps its own reference model of the flip-flops and flags any deviation. It sits beside the flip-flop instances on the same clock, in benches and optionally on silicon as a built-in self-check. Detected errors are reported as a pulse, a sticky flag and a saturating count.

## Interface
- WIDTH, 1: number of JK flip-flops monitored in parallel
- CNT_W, 8: width of the error counter
- iClk  in  1  clock, rising edge; the same clock as the monitored flip-flops
- iRst_n  in  1  reset, asynchronous, active-low
- iEn  in  1  monitor enable; low forces IDLE
- iClr  in  1  synchronous clear of the counter and the sticky flag
- iJ  in  WIDTH  J inputs as driven to the flip-flops
- iK  in  WIDTH  K inputs as driven to the flip-flops
- iQ  in  WIDTH  Q outputs of the flip-flops
- iQn  in  WIDTH  Qn outputs of the flip-flops
- oSync  out  1  high while in TRACK
- oExpQ  out  WIDTH  model's predicted Q
- oErr  out  1  one-cycle error pulse
- oErrMask  out  WIDTH  per-bit error flags, valid while oErr is high
- oErrSticky  out  1  set on any error; cleared only by iClr or reset
- oErrCnt  out  CNT_W  saturating count of error cycles

## Operation
- Model function: jk(J,K,Q) = (J & ~Q) | (~K & Q), evaluated per bit (00 hold, 10 set, 01 reset, 11 toggle).
- States and transitions:
  - IDLE: if iEn=1, go to ACQUIRE.
  - ACQUIRE: expQ <= jk(iJ,iK,iQ); go to TRACK. No Q comparison is made in this state.
  - TRACK: compare iQ against expQ, then update expQ.
  - Any state: if iEn=0, go to IDLE.
- Q error (TRACK only): bit i errs when iQ[i] != expQ[i].
- Complement error (ACQUIRE and TRACK): bit i errs when iQn[i] != ~iQ[i].
- oErrMask is the OR of the Q-error and complement-error bits.
- Model update in TRACK:
  - no Q error: expQ <= jk(iJ,iK,expQ)
  - any Q error: expQ <= jk(iJ,iK,iQ). The model resyncs, so one fault produces exactly one error cycle.
- Counter: oErrCnt increments by 1 per error cycle, regardless of how many bits err. It saturates at 2^CNT_W-1 with no wrap.
- iClr=1 zeroes oErrCnt and oErrSticky. If an error occurs in the same cycle, the clear wins and that error is not counted. oErr/oErrMask still pulse.
- Leaving TRACK (iEn=0) holds the counter and sticky flag; expQ holds.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, oSync=0, oExpQ=0, oErr=0, oErrMask=0, oErrSticky=0, oErrCnt=0.
- iJ/iK/iQ/iQn are sampled at each rising edge. iQ sampled at edge t is the flip-flop result of edge t-1.
- Latency:
  - An error on the inputs before edge t appears on oErr/oErrMask after edge t, for exactly one cycle.
  - oErrCnt and oErrSticky update at the same edge.
- oSync rises one cycle after the ACQUIRE edge, i.e. two edges after iEn rises.
- Asynchronous reset mid-TRACK returns to IDLE immediately; all state is lost.

## Structure
- Shared package ff_jk_pkg holds:
  - state enum {IDLE, ACQUIRE, TRACK}
  - function jk_next(J,K,Q), reused by the flip-flop model and by benches
- One natural sub-module: ff_jk_err_cnt (saturating counter with clear priority), reusable by other checkers.
- The FSM and compare logic stay in the top module.

## Test plan
- Reset, iEn=1, WIDTH=1, JK sequence 00,10,01,11,11 driven into a correct flip-flop:
  - oSync=1 from the second edge on
  - oErr never asserts
  - oExpQ tracks iQ: 0,1,0,1,0
- Injected fault: force iQ=0 for one cycle when expQ=1:
  - oErr=1 and oErrMask=1 for one cycle
  - oErrCnt=1, oErrSticky=1
  - the next cycle has no error (resync)
- Complement fault: iQn=iQ=1 while in ACQUIRE:
  - oErr pulses
  - the state still advances to TRACK
- Saturation: CNT_W=2 with a persistent fault:
  - oErrCnt goes 1,2,3,3,3
  - then iClr=1 together with a fault -> oErrCnt=0, oErrSticky=0, oErr=1
- iEn dropped mid-TRACK:
  - oSync=0 at the next edge; counter held
  - re-enable -> ACQUIRE, then TRACK
- Asynchronous reset asserted between edges during TRACK:
  - all outputs go to 0 immediately, without waiting for an edge
